uart_prog_loader: RTL and testbench

//   Consumes the byte stream from uart_receiver (o_Rx_DV/o_Rx_Byte) and assembles it into
//   32-bit little-endian words written to on-chip instruction/data memory over a req/gnt

---
 rtl/uart_prog_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART boot loader: packs received bytes into little-endian 32-bit words and writes them over a
// req/gnt memory port until the end-marker word. Optional checksum byte: UART_LOADER_CHKSUM_EN.
module uart_prog_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int unsigned       MAX_WORDS = 4096,
    parameter logic [31:0]       END_WORD  = 32'h0000_0FFF
) (
    input  logic              i_Clock,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       words_o,
    output logic              err_overrun_o,
    output logic              err_full_o,
    output logic              err_chksum_o
);

`ifdef UART_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHKSUM  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;
    localparam state_t END_ST = ST_CHKSUM;

    function automatic logic [7:0] byte_sum(input logic [31:0] w);
        byte_sum = w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

    logic [7:0] chk_r;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd4
    } state_t;
    localparam state_t END_ST = ST_DONE;
`endif

    state_t      state_r, state_n;
    logic [1:0]  byte_cnt_r;
    logic [23:0] word_r;
    logic        pend_end_r;
    logic        pend_idle_r;
    logic        assembling_s;
    logic        word_ev_s;
    logic        gnt_s;
    logic        is_end_s;
    logic        full_s;
    logic        busy_n_s;
    logic [31:0] assembled_s;

    // Next-state decode and per-cycle strobes
    always_comb begin
        state_n      = state_r;
        assembling_s = 1'b0;
        word_ev_s    = 1'b0;
        gnt_s        = 1'b0;
        assembled_s  = {i_Rx_Byte, word_r};
        is_end_s     = (assembled_s == END_WORD);
        full_s       = (words_o == 16'(MAX_WORDS));
        case (state_r)
            ST_IDLE: begin
                if (en_i) state_n = ST_COLLECT;
                else      state_n = ST_IDLE;
            end
            ST_COLLECT: begin
                assembling_s = en_i;
                word_ev_s    = en_i && i_Rx_DV && (byte_cnt_r == 2'd3);
                if (!en_i)                      state_n = ST_IDLE;
                else if (word_ev_s && is_end_s) state_n = END_ST;
                else if (word_ev_s && !full_s)  state_n = ST_WRITE;
                else                            state_n = ST_COLLECT;
            end
            ST_WRITE: begin
                // Bytes keep assembling during a write; only the terminal marker is deferred.
                assembling_s = !pend_end_r;
                word_ev_s    = !pend_end_r && i_Rx_DV && (byte_cnt_r == 2'd3);
                gnt_s        = mem_req_o && mem_gnt_i;
                if (!gnt_s)                                     state_n = ST_WRITE;
                else if (pend_idle_r || !en_i)                  state_n = ST_IDLE;
                else if (pend_end_r || (word_ev_s && is_end_s)) state_n = END_ST;
                else                                            state_n = ST_COLLECT;
            end
`ifdef UART_LOADER_CHKSUM_EN
            ST_CHKSUM: begin
                if (!en_i)        state_n = ST_IDLE;
                else if (i_Rx_DV) state_n = ST_DONE;
                else              state_n = ST_CHKSUM;
            end
`endif
            ST_DONE: begin
                if (!en_i) state_n = ST_IDLE;
                else       state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Busy flag of the upcoming state
    always_comb begin
        busy_n_s = (state_n == ST_COLLECT) || (state_n == ST_WRITE);
`ifdef UART_LOADER_CHKSUM_EN
        if (state_n == ST_CHKSUM) busy_n_s = 1'b1;
        else                      busy_n_s = busy_n_s;
`endif
    end

    // State register
    always_ff @(posedge i_Clock) begin
        if (rst_i) state_r <= ST_IDLE;
        else       state_r <= state_n;
    end

    // Datapath, memory handshake outputs and sticky status
    always_ff @(posedge i_Clock) begin
        if (rst_i) begin
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= 4'h0;
            mem_addr_o    <= BASE_ADDR;
            mem_wdata_o   <= 32'h0000_0000;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            words_o       <= 16'd0;
            err_overrun_o <= 1'b0;
            err_full_o    <= 1'b0;
            err_chksum_o  <= 1'b0;
            byte_cnt_r    <= 2'd0;
            word_r        <= 24'd0;
            pend_end_r    <= 1'b0;
            pend_idle_r   <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
            chk_r         <= 8'd0;
`endif
        end else begin
            mem_req_o <= (state_n == ST_WRITE);
            mem_we_o  <= (state_n == ST_WRITE);
            mem_be_o  <= (state_n == ST_WRITE) ? 4'hF : 4'h0;
            busy_o    <= busy_n_s;
            done_o    <= (state_n == ST_DONE);
            if (state_n == ST_IDLE) begin
                mem_addr_o    <= BASE_ADDR;
                words_o       <= 16'd0;
                err_overrun_o <= 1'b0;
                err_full_o    <= 1'b0;
                err_chksum_o  <= 1'b0;
                byte_cnt_r    <= 2'd0;
                word_r        <= 24'd0;
                pend_end_r    <= 1'b0;
                pend_idle_r   <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
                chk_r         <= 8'd0;
`endif
            end else begin
                if (assembling_s && i_Rx_DV) begin
                    byte_cnt_r <= byte_cnt_r + 2'd1;
                    case (byte_cnt_r)
                        2'd0:    word_r[7:0]   <= i_Rx_Byte;
                        2'd1:    word_r[15:8]  <= i_Rx_Byte;
                        2'd2:    word_r[23:16] <= i_Rx_Byte;
                        default: word_r        <= word_r;
                    endcase
                end
                if (word_ev_s && !is_end_s) begin
                    if (state_r == ST_WRITE) err_overrun_o <= 1'b1;
                    else if (full_s)         err_full_o    <= 1'b1;
                    else                     mem_wdata_o   <= assembled_s;
`ifdef UART_LOADER_CHKSUM_EN
                    chk_r <= chk_r + byte_sum(assembled_s);
`endif
                end
                if (word_ev_s && is_end_s && (state_r == ST_WRITE)) pend_end_r <= 1'b1;
                if ((state_r == ST_WRITE) && !en_i) pend_idle_r <= 1'b1;
                if (gnt_s) begin
                    mem_addr_o <= mem_addr_o + ADDR_W'(4);
                    words_o    <= words_o + 16'd1;
                end
                // Pending flags only live for the duration of one write.
                if (state_n != ST_WRITE) begin
                    pend_end_r  <= 1'b0;
                    pend_idle_r <= 1'b0;
                end
`ifdef UART_LOADER_CHKSUM_EN
                if ((state_r == ST_CHKSUM) && i_Rx_DV && (i_Rx_Byte != chk_r)) err_chksum_o <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed scenarios plus randomized images checked
// against a word-list reference model; a memory responder records granted writes.
module tb_uart_prog_loader;
    localparam int unsigned TB_MAX = 4;
    localparam logic [31:0] END_W  = 32'h0000_0FFF;

    logic        i_Clock = 1'b0;
    logic        rst_i, en_i, i_Rx_DV, mem_gnt_i;
    logic [7:0]  i_Rx_Byte;
    logic        mem_req_o, mem_we_o, busy_o, done_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [15:0] words_o;
    logic        err_overrun_o, err_full_o, err_chksum_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] wr_q[$];
    int gnt_lat = 0;
    bit gnt_block = 1'b0;
    int unstable_cnt = 0;
    int late_drop_cnt = 0;

    always #5 i_Clock = ~i_Clock;

    uart_prog_loader #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(TB_MAX), .END_WORD(END_W)) dut (
        .i_Clock(i_Clock), .rst_i(rst_i), .en_i(en_i), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .busy_o(busy_o), .done_o(done_o),
        .words_o(words_o), .err_overrun_o(err_overrun_o), .err_full_o(err_full_o),
        .err_chksum_o(err_chksum_o));

    // Memory responder: grants after gnt_lat request cycles, logs writes, watches request stability
    initial begin
        int wait_cnt;
        bit active;
        logic [31:0] a0, d0;
        mem_gnt_i = 1'b0;
        wait_cnt = 0;
        active = 1'b0;
        forever begin
            @(negedge i_Clock);
            if (mem_gnt_i) begin
                mem_gnt_i = 1'b0;
                if (mem_req_o !== 1'b0) late_drop_cnt++;
                active = 1'b0;
                wait_cnt = 0;
            end else if (mem_req_o === 1'b1) begin
                if (!active) begin
                    active = 1'b1; a0 = mem_addr_o; d0 = mem_wdata_o; wait_cnt = 0;
                end else if (mem_addr_o !== a0 || mem_wdata_o !== d0) unstable_cnt++;
                if (mem_we_o !== 1'b1 || mem_be_o !== 4'hF) unstable_cnt++;
                if (!gnt_block && wait_cnt >= gnt_lat) begin
                    mem_gnt_i = 1'b1;
                    wr_q.push_back({mem_addr_o, mem_wdata_o});
                end
                wait_cnt++;
            end else begin
                active = 1'b0;
                wait_cnt = 0;
                if (mem_we_o !== 1'b0 || mem_be_o !== 4'h0) unstable_cnt++;
            end
        end
    end

    function automatic logic [7:0] bsum(input logic [31:0] w);
        bsum = w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_Clock);
        i_Rx_DV = 1'b1; i_Rx_Byte = b;
        @(negedge i_Clock);
        i_Rx_DV = 1'b0; i_Rx_Byte = 8'($urandom);
        tick(6);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic restart();
        en_i = 1'b0;
        tick(2);
        wr_q.delete();
        unstable_cnt = 0;
        late_drop_cnt = 0;
        en_i = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
        tick(3);
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_be_o, busy_o, done_o, words_o, err_overrun_o, err_full_o, err_chksum_o, mem_wdata_o} !== 59'd0) begin
            n_bad++; $display("FAIL reset_outputs: got req=%b be=%h busy=%b done=%b words=%0d errs=%b%b%b wdata=%h, want all 0",
                mem_req_o, mem_be_o, busy_o, done_o, words_o, err_overrun_o, err_full_o, err_chksum_o, mem_wdata_o);
        end
        n_cmp++;
        if (mem_addr_o !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_addr: got %h want 00000000", mem_addr_o); end
        rst_i = 1'b0;
        tick(1);
    endtask

    task automatic test_single_write();
        restart();
        gnt_lat = 3;
        send_word(32'h1234_5678);
        tick(2);
        n_cmp++;
        if (wr_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", wr_q.size()); end
        else begin
            n_cmp++;
            if (wr_q[0] !== {32'h0000_0000, 32'h1234_5678}) begin n_bad++; $display("FAIL single_write: got %h want 0000000012345678", wr_q[0]); end
        end
        n_cmp++;
        if (words_o !== 16'd1 || mem_addr_o !== 32'h4 || mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL single_state: got words=%0d addr=%h req=%b busy=%b want 1 4 0 1", words_o, mem_addr_o, mem_req_o, busy_o);
        end
        n_cmp++;
        if (unstable_cnt !== 0 || late_drop_cnt !== 0) begin n_bad++; $display("FAIL single_handshake: got unstable=%0d late=%0d want 0 0", unstable_cnt, late_drop_cnt); end
    endtask

    task automatic test_end_marker();
        restart();
        gnt_lat = 1;
        send_word(32'hA1B2_C3D4);
        send_word(32'h0BAD_F00D);
        send_word(END_W);
`ifdef UART_LOADER_CHKSUM_EN
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL end_chk_wait: got done=%b busy=%b want 0 1", done_o, busy_o); end
        send_byte(bsum(32'hA1B2_C3D4) + bsum(32'h0BAD_F00D));
`endif
        send_word(32'h5555_AAAA);
        n_cmp++;
        if (wr_q.size() !== 2) begin n_bad++; $display("FAIL end_count: got %0d want 2", wr_q.size()); end
        else begin
            n_cmp++;
            if (wr_q[0] !== {32'h0, 32'hA1B2_C3D4} || wr_q[1] !== {32'h4, 32'h0BAD_F00D}) begin
                n_bad++; $display("FAIL end_writes: got %h %h want 00000000a1b2c3d4 000000040badf00d", wr_q[0], wr_q[1]);
            end
        end
        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || words_o !== 16'd2 || err_chksum_o !== 1'b0) begin
            n_bad++; $display("FAIL end_done: got done=%b busy=%b words=%0d chk=%b want 1 0 2 0", done_o, busy_o, words_o, err_chksum_o);
        end
    endtask

    task automatic test_overrun();
        restart();
        gnt_block = 1'b1;
        send_word(32'h1234_5678);
        send_word(32'hAABB_CCDD);
        n_cmp++;
        if (err_overrun_o !== 1'b1 || mem_req_o !== 1'b1 || wr_q.size() !== 0) begin
            n_bad++; $display("FAIL overrun_flag: got ovr=%b req=%b writes=%0d want 1 1 0", err_overrun_o, mem_req_o, wr_q.size());
        end
        gnt_block = 1'b0; gnt_lat = 0;
        tick(4);
        n_cmp++;
        if (wr_q.size() !== 1 || words_o !== 16'd1 || unstable_cnt !== 0) begin
            n_bad++; $display("FAIL overrun_complete: got writes=%0d words=%0d unstable=%0d want 1 1 0", wr_q.size(), words_o, unstable_cnt);
        end else begin
            n_cmp++;
            if (wr_q[0] !== {32'h0, 32'h1234_5678}) begin n_bad++; $display("FAIL overrun_data: got %h want 0000000012345678", wr_q[0]); end
        end
    endtask

    task automatic test_full();
        restart();
        gnt_lat = 0;
        for (int k = 0; k < 5; k++) send_word(32'h1000_0000 + 32'(k));
        n_cmp++;
        if (wr_q.size() !== 4 || err_full_o !== 1'b1 || mem_addr_o !== 32'h10 || words_o !== 16'd4 || err_overrun_o !== 1'b0) begin
            n_bad++; $display("FAIL full: got writes=%0d full=%b addr=%h words=%0d ovr=%b want 4 1 10 4 0",
                wr_q.size(), err_full_o, mem_addr_o, words_o, err_overrun_o);
        end
    endtask

    task automatic test_en_drop();
        restart();
        gnt_lat = 2;
        send_byte(8'hAA);
        send_byte(8'hBB);
        en_i = 1'b0;
        tick(2);
        n_cmp++;
        if (busy_o !== 1'b0 || words_o !== 16'd0) begin n_bad++; $display("FAIL en_idle: got busy=%b words=%0d want 0 0", busy_o, words_o); end
        en_i = 1'b1;
        tick(1);
        send_word(32'hCAFE_F00D);
        n_cmp++;
        if (wr_q.size() !== 1) begin n_bad++; $display("FAIL en_count: got %0d want 1", wr_q.size()); end
        else begin
            n_cmp++;
            if (wr_q[0] !== {32'h0, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL en_word: got %h want 00000000cafef00d", wr_q[0]); end
        end
    endtask

    task automatic test_chksum();
`ifdef UART_LOADER_CHKSUM_EN
        for (int t = 0; t < 2; t++) begin
            restart();
            send_word(32'h0403_0201);
            send_word(END_W);
            send_byte((t == 0) ? 8'h0A : 8'h0B);
            n_cmp++;
            if (done_o !== 1'b1 || err_chksum_o !== 1'(t)) begin
                n_bad++; $display("FAIL chksum_%0d: got done=%b err=%b want 1 %0d", t, done_o, err_chksum_o, t);
            end
        end
`else
        restart();
        send_word(32'h0403_0201);
        send_word(END_W);
        n_cmp++;
        if (done_o !== 1'b1 || err_chksum_o !== 1'b0 || wr_q.size() !== 1) begin
            n_bad++; $display("FAIL chksum_off: got done=%b err=%b writes=%0d want 1 0 1", done_o, err_chksum_o, wr_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        restart();
        gnt_block = 1'b1;
        send_word(32'hDEAD_BEEF);
        rst_i = 1'b1;
        tick(1);
        n_cmp++;
        if (mem_req_o !== 1'b0 || words_o !== 16'd0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid: got req=%b words=%0d busy=%b want 0 0 0", mem_req_o, words_o, busy_o);
        end
        rst_i = 1'b0;
        gnt_block = 1'b0;
        tick(2);
        n_cmp++;
        if (wr_q.size() !== 0) begin n_bad++; $display("FAIL rst_mid_writes: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [63:0] exp_q[$];
            logic [31:0] w;
            logic [7:0] chk, cbyte;
            bit exp_full, exp_cerr;
            int nw;
            restart();
            gnt_lat = $urandom_range(0, 3);
            nw = $urandom_range(0, 6);
            chk = 8'd0; exp_full = 1'b0; exp_cerr = 1'b0;
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                while (w == END_W) w = $urandom;
                chk = chk + bsum(w);
                if (k < TB_MAX) exp_q.push_back({32'(4 * k), w});
                else exp_full = 1'b1;
                send_word(w);
            end
            send_word(END_W);
`ifdef UART_LOADER_CHKSUM_EN
            cbyte = ($urandom_range(0, 1) == 0) ? chk : chk + 8'(($urandom_range(1, 255)));
            exp_cerr = (cbyte != chk);
            send_byte(cbyte);
`else
            cbyte = chk;
`endif
            tick(2);
            n_cmp++;
            if (wr_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, wr_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_write%0d: got %h want %h", it, i, wr_q[i], exp_q[i]); end
            end
            n_cmp++;
            if (done_o !== 1'b1 || words_o !== 16'(exp_q.size()) || mem_addr_o !== 32'(4 * exp_q.size()) ||
                err_full_o !== exp_full || err_overrun_o !== 1'b0 || err_chksum_o !== exp_cerr || unstable_cnt !== 0 || late_drop_cnt !== 0) begin
                n_bad++; $display("FAIL rand%0d_status: got done=%b words=%0d addr=%h full=%b ovr=%b chk=%b unst=%0d late=%0d want 1 %0d %h %b 0 %b 0 0",
                    it, done_o, words_o, mem_addr_o, err_full_o, err_overrun_o, err_chksum_o, unstable_cnt, late_drop_cnt,
                    exp_q.size(), 32'(4 * exp_q.size()), exp_full, exp_cerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_end_marker();
        test_overrun();
        test_full();
        test_en_drop();
        test_chksum();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
